interp_col_loop_ctrl: RTL and testbench

Loop controller for the interpolation datapath. It holds the registered column and row counters and advances the column through the 4-bit counter adder (col + step). Each (row, column) pair drives the buffer column select and a read strobe toward the interpolation buffer. A start/busy/done handshake faces the top-level control, and the downstream ready_in input stalls the loop.

---
 rtl/interp_col_loop_ctrl.sv | 94 +++++++++
 tb/tb_interp_col_loop_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/interp_col_loop_ctrl.sv
// interp_col_loop_ctrl: column/row loop for the interpolation buffer; optional stall counter under INTERP_LOOP_STALL_CNT_EN
module interp_col_loop_ctrl #(
  parameter int NUM_COLS = 13,
  parameter int NUM_ROWS = 8,
  parameter int CNT_W    = 4,
  parameter int ROW_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] step,
  input  logic             ready_in,
  output logic [CNT_W-1:0] col_sel,
  output logic [ROW_W-1:0] row_idx,
  output logic             rd_en,
  output logic             last_col,
  output logic             busy,
  output logic             done
`ifdef INTERP_LOOP_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_step;
  logic [CNT_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_rd_en;
  logic             r_done;
  logic [CNT_W:0]   w_sum;
  logic             w_wrap;
  logic             w_acc;
  logic             w_last_row;
  assign w_sum      = {1'b0, r_col} + {1'b0, r_step};
  assign w_wrap     = w_sum >= (CNT_W+1)'(NUM_COLS);
  assign w_acc      = r_rd_en & ready_in;
  assign w_last_row = r_row == ROW_W'(NUM_ROWS - 1);
  assign col_sel    = r_col;
  assign row_idx    = r_row;
  assign rd_en      = r_rd_en;
  assign last_col   = r_rd_en & w_wrap;
  assign busy       = r_state != IDLE;
  assign done       = r_done;
  // loop state machine: each accepted beat steps the column, wrapping into the next row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_step  <= (step == '0) ? CNT_W'(1) : step;
          r_col   <= '0;
          r_row   <= '0;
          r_rd_en <= 1'b1;
          r_state <= RUN;
        end
        RUN: if (w_acc) begin
          if (w_wrap && w_last_row) begin
            r_rd_en <= 1'b0;
            r_col   <= '0;
            r_row   <= '0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (w_wrap) begin
            r_col <= '0;
            r_row <= r_row + ROW_W'(1);
          end else begin
            r_col <= w_sum[CNT_W-1:0];
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
`ifdef INTERP_LOOP_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  assign stall_cnt = r_stall_cnt;
  // saturating count of cycles a pending read waits on ready_in; cleared by an accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_stall_cnt <= '0;
    else if (r_state == IDLE && start) r_stall_cnt <= '0;
    else if (r_state == RUN && r_rd_en && !ready_in && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_interp_col_loop_ctrl.sv
// tb_interp_col_loop_ctrl: scoreboard bench for the interpolation column loop controller
module tb_interp_col_loop_ctrl;
  localparam int COLS = 13;
  localparam int ROWS = 2;
  typedef struct {int col; int row; int last;} beat_t;
  logic       clk = 0;
  logic       rst = 1;
  logic       start = 0;
  logic       start_b = 0;
  logic [3:0] step = 0;
  logic       ready_in = 1;
  logic [3:0] col_sel, col_b;
  logic [3:0] row_idx, row_b;
  logic       rd_en, last_col, busy, done;
  logic       rd_b, last_b, busy_b, done_b;
  int         total = 0;
  int         bad = 0;
  beat_t      exp_q[$];
`ifdef INTERP_LOOP_STALL_CNT_EN
  logic [15:0] stall_cnt, stall_b;
`endif
  always #5 clk = ~clk;
  interp_col_loop_ctrl #(.NUM_COLS(COLS), .NUM_ROWS(ROWS), .CNT_W(4), .ROW_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .ready_in(ready_in),
    .col_sel(col_sel), .row_idx(row_idx), .rd_en(rd_en), .last_col(last_col),
    .busy(busy), .done(done)
`ifdef INTERP_LOOP_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  interp_col_loop_ctrl #(.NUM_COLS(16), .NUM_ROWS(1), .CNT_W(4), .ROW_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .step(step), .ready_in(ready_in),
    .col_sel(col_b), .row_idx(row_b), .rd_en(rd_b), .last_col(last_b),
    .busy(busy_b), .done(done_b)
`ifdef INTERP_LOOP_STALL_CNT_EN
    , .stall_cnt(stall_b)
`endif
  );
  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    total++;
    if (col_sel !== 0 || row_idx !== 0 || rd_en !== 0 || last_col !== 0 || busy !== 0 || done !== 0)
      begin bad++; $display("FAIL reset col=%0d row=%0d rd=%b last=%b busy=%b done=%b want all 0", col_sel, row_idx, rd_en, last_col, busy, done); end
    total++;
    if (col_b !== 0 || rd_b !== 0 || busy_b !== 0 || done_b !== 0)
      begin bad++; $display("FAIL reset_b col=%0d rd=%b busy=%b done=%b want all 0", col_b, rd_b, busy_b, done_b); end
    rst = 0;
    @(negedge clk);
  endtask
  task automatic run_block(input int s, input bit stall, input bit poke);
    int se, beats, nexp, stalls;
    bit fin;
    beat_t e;
    se = (s == 0) ? 1 : s;
    nexp = 0;
    exp_q.delete();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c += se) begin
        exp_q.push_back('{c, r, (c + se >= COLS) ? 1 : 0});
        nexp++;
      end
    step = 4'(s); start = 1; ready_in = 1;
    @(negedge clk);
    start = 0;
    total++;
    if (rd_en !== 1 || busy !== 1)
      begin bad++; $display("FAIL latency step=%0d rd=%b busy=%b want 1/1", s, rd_en, busy); end
    beats = 0; stalls = 0; fin = 0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (done === 1) fin = 1;
      else begin
        start = poke && row_idx == 0 && col_sel == 3;
        if (stall && col_sel == 5 && stalls < 3) begin
          ready_in = 0;
          stalls++;
          total++;
          if (rd_en !== 1) begin bad++; $display("FAIL stall_hold rd=%b want 1", rd_en); end
        end else begin
          ready_in = 1;
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL extra_beat col=%0d row=%0d rd=%b want no beat", col_sel, row_idx, rd_en);
          end else begin
            e = exp_q.pop_front();
            if (rd_en !== 1 || col_sel !== 4'(e.col) || row_idx !== 4'(e.row) || last_col !== 1'(e.last))
              begin bad++; $display("FAIL beat step=%0d rd=%b col=%0d row=%0d last=%b want 1/%0d/%0d/%0d", s, rd_en, col_sel, row_idx, last_col, e.col, e.row, e.last); end
          end
          beats++;
        end
        @(negedge clk);
      end
    end
    ready_in = 1; start = 0;
    total++;
    if (!fin) begin bad++; $display("FAIL done_timeout step=%0d done=%b want 1", s, done); end
    total++;
    if (beats != nexp || exp_q.size() != 0)
      begin bad++; $display("FAIL beat_count step=%0d got=%0d want=%0d", s, beats, nexp); end
    exp_q.delete();
    total++;
    if (busy !== 1 || rd_en !== 0 || last_col !== 0 || col_sel !== 0 || row_idx !== 0)
      begin bad++; $display("FAIL done_cycle busy=%b rd=%b last=%b col=%0d row=%0d want 1/0/0/0/0", busy, rd_en, last_col, col_sel, row_idx); end
    start = poke;
    @(negedge clk);
    start = 0;
    total++;
    if (done !== 0 || busy !== 0)
      begin bad++; $display("FAIL after_done done=%b busy=%b want 0/0", done, busy); end
    @(negedge clk);
    total++;
    if (rd_en !== 0 || busy !== 0)
      begin bad++; $display("FAIL idle_hold rd=%b busy=%b want 0/0", rd_en, busy); end
`ifdef INTERP_LOOP_STALL_CNT_EN
    total++;
    if (stall_cnt !== 16'(stall ? 3 : 0))
      begin bad++; $display("FAIL stall_cnt got=%0d want=%0d", stall_cnt, stall ? 3 : 0); end
`endif
  endtask
  task automatic test_reset_mid();
    int seen;
    bit hit;
    step = 1; start = 1; ready_in = 1;
    @(negedge clk);
    start = 0;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (row_idx == 1 && col_sel == 7) hit = 1;
      else @(negedge clk);
    end
    total++;
    if (!hit) begin bad++; $display("FAIL reach_r1c7 col=%0d row=%0d want 7/1", col_sel, row_idx); end
    #2 rst = 1;
    #1;
    total++;
    if (col_sel !== 0 || row_idx !== 0 || rd_en !== 0 || last_col !== 0 || busy !== 0 || done !== 0)
      begin bad++; $display("FAIL async_reset col=%0d row=%0d rd=%b last=%b busy=%b done=%b want all 0", col_sel, row_idx, rd_en, last_col, busy, done); end
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 0 || busy !== 0) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL no_done_after_reset active_cycles=%0d want 0", seen); end
    run_block(1, 0, 0);
  endtask
  task automatic test_wrap_16();
    step = 15; start_b = 1;
    @(negedge clk);
    start_b = 0;
    total++;
    if (rd_b !== 1 || col_b !== 0 || last_b !== 0 || row_b !== 0)
      begin bad++; $display("FAIL wrap16_b0 rd=%b col=%0d last=%b row=%0d want 1/0/0/0", rd_b, col_b, last_b, row_b); end
    @(negedge clk);
    total++;
    if (rd_b !== 1 || col_b !== 15 || last_b !== 1)
      begin bad++; $display("FAIL wrap16_b1 rd=%b col=%0d last=%b want 1/15/1", rd_b, col_b, last_b); end
    @(negedge clk);
    total++;
    if (done_b !== 1 || rd_b !== 0 || busy_b !== 1)
      begin bad++; $display("FAIL wrap16_done done=%b rd=%b busy=%b want 1/0/1", done_b, rd_b, busy_b); end
    @(negedge clk);
    total++;
    if (done_b !== 0 || busy_b !== 0)
      begin bad++; $display("FAIL wrap16_idle done=%b busy=%b want 0/0", done_b, busy_b); end
  endtask
  initial begin
    test_reset();
    run_block(1, 0, 0);
    run_block(4, 0, 0);
    run_block(0, 0, 0);
    run_block(1, 1, 0);
    run_block(1, 0, 1);
    test_reset_mid();
    test_wrap_16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
